// File: rtl/coin_payer_if.sv
// Coin-feeder bus: host request, vending-machine strobe and coin/result outputs.
// master = host/sequencer side, slave = coin_payer.
interface coin_payer_if #(
  parameter int AMT_W = 4
);
  logic             iStart;
  logic [AMT_W-1:0] iAmount;
  logic             iCola;
  logic             poOne;
  logic             poHalf;
  logic             oBusy;
  logic             oDone;
  logic             oTimeout;

  modport master (
    output iStart, iAmount, iCola,
    input  poOne, poHalf, oBusy, oDone, oTimeout
  );

  modport slave (
    input  iStart, iAmount, iCola,
    output poOne, poHalf, oBusy, oDone, oTimeout
  );
endinterface

// File: rtl/coin_payer.sv
// coin_payer: pays a half-yuan amount as 1-yuan/0.5-yuan pulses, then waits for OCola.
// Optional `PAY_STATS_EN adds oVendCnt, a saturating count of completed (oDone) vends.
module coin_payer #(
  parameter int AMT_W   = 4,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        sysRstN,
  coin_payer_if.slave bus
`ifdef PAY_STATS_EN
  ,
  output logic [7:0]  oVendCnt
`endif
);

  localparam int CNT_W = $clog2(((GAP > TIMEOUT) ? GAP : TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] AMT_TWO  = AMT_W'(2);

  typedef enum logic [1:0] {IDLE, PAY, GAPW, WAIT} state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             one_q, one_d;
  logic             half_q, half_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;

  logic [AMT_W-1:0] coin_src;
  logic             coin_one;
  logic             coin_half;
  logic [AMT_W-1:0] rem_after;

  // Next coin is drawn from the fresh request in IDLE, otherwise from what remains.
  always_comb begin
    coin_src  = (state_q == IDLE) ? bus.iAmount : rem_q;
    coin_one  = (coin_src >= AMT_TWO);
    coin_half = (coin_src == AMT_ONE);
    rem_after = coin_one ? (coin_src - AMT_TWO) : '0;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    one_d   = 1'b0;
    half_d  = 1'b0;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.iStart && (bus.iAmount != '0)) begin
          state_d = PAY;
          one_d   = coin_one;
          half_d  = coin_half;
          rem_d   = rem_after;
          cnt_d   = '0;
        end
      end
      PAY: begin
        if (bus.iCola) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rem_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = (rem_q == '0) ? WAIT : GAPW;
          cnt_d   = CNT_ONE;
        end
      end
      GAPW: begin
        // An early vend abandons the coins still owed.
        if (bus.iCola) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rem_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = PAY;
          one_d   = coin_one;
          half_d  = coin_half;
          rem_d   = rem_after;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT: begin
        // iCola takes priority over the timeout on the final edge.
        if (bus.iCola) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      one_q   <= 1'b0;
      half_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      one_q   <= one_d;
      half_q  <= half_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.poOne    = one_q;
  assign bus.poHalf   = half_q;
  assign bus.oDone    = done_q;
  assign bus.oTimeout = tmo_q;
  assign bus.oBusy    = (state_q != IDLE);

`ifdef PAY_STATS_EN
  logic [7:0] vend_cnt_q, vend_cnt_d;

  always_comb begin
    vend_cnt_d = vend_cnt_q;
    if (done_q && (vend_cnt_q != 8'hFF)) vend_cnt_d = vend_cnt_q + 8'd1;
  end

  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN) vend_cnt_q <= 8'd0;
    else          vend_cnt_q <= vend_cnt_d;
  end

  assign oVendCnt = vend_cnt_q;
`endif

endmodule

// File: tb/tb_coin_payer.sv
// Scoreboard bench for coin_payer (GAP=4, TIMEOUT=16): stimulus queues expected
// coin/result events with their cycle; a negedge monitor pops and compares them.
module tb_coin_payer;
  localparam int AMT_W   = 4;
  localparam int GAP     = 4;
  localparam int TIMEOUT = 16;
  localparam int K_ONE = 1, K_HALF = 2, K_DONE = 3, K_TMO = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic sys_clk = 1'b0;
  logic sysRstN;
  always #5 sys_clk = ~sys_clk;

  coin_payer_if #(.AMT_W(AMT_W)) bus ();
`ifdef PAY_STATS_EN
  logic [7:0] vend_cnt;
`endif

  coin_payer #(.AMT_W(AMT_W), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk (sys_clk),
    .sysRstN (sysRstN),
    .bus     (bus)
`ifdef PAY_STATS_EN
    ,
    .oVendCnt(vend_cnt)
`endif
  );

  int  cyc = 0;
  int  t0 = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  n_done = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];
  bit  busy_set[int];

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_ONE:   return "poOne";
      K_HALF:  return "poHalf";
      K_DONE:  return "oDone";
      K_TMO:   return "oTimeout";
      default: return "none";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic got(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected %s at cycle %0d: got pulse, expected none", kname(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      chk({"event kind ", kname(kind)}, kind, e.kind);
      chk({"event cycle ", kname(kind)}, cyc, e.cyc);
    end
  endtask

  always @(negedge sys_clk) begin
    if (mon_en) begin
      chk("oBusy", int'(bus.oBusy), int'(busy_set.exists(cyc)));
      if (bus.poOne && bus.poHalf) chk("coin exclusive", 1, 0);
      if (bus.poOne)    got(K_ONE);
      if (bus.poHalf)   got(K_HALF);
      if (bus.oDone)    got(K_DONE);
      if (bus.oTimeout) got(K_TMO);
    end
  end

  task automatic ev(input int kind, input int rel);
    ev_t e;
    e.kind = kind;
    e.cyc  = t0 + rel;
    exp_q.push_back(e);
  endtask

  task automatic set_busy(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) busy_set[t0 + c] = 1'b1;
  endtask

  task automatic at(input int rel);
    while (cyc < t0 + rel) @(negedge sys_clk);
  endtask

  task automatic begin_run(input int amt);
    t0 = cyc;
    bus.iStart  = 1'b1;
    bus.iAmount = AMT_W'(amt);
  endtask

  task automatic end_start();
    at(1);
    bus.iStart = 1'b0;
  endtask

  task automatic cola(input int rel);
    at(rel);
    bus.iCola = 1'b1;
    at(rel + 1);
    bus.iCola = 1'b0;
  endtask

  task automatic drain(input int rel);
    at(rel);
    chk("pending events", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " poOne"}, int'(bus.poOne), 0);
    chk({tag, " poHalf"}, int'(bus.poHalf), 0);
    chk({tag, " oBusy"}, int'(bus.oBusy), 0);
    chk({tag, " oDone"}, int'(bus.oDone), 0);
    chk({tag, " oTimeout"}, int'(bus.oTimeout), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iStart  = 1'b0;
    bus.iAmount = '0;
    bus.iCola   = 1'b0;
    sysRstN     = 1'b1;
    #1 sysRstN  = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk_all_zero("reset");
    sysRstN = 1'b1;
    @(negedge sys_clk);
    mon_en = 1'b1;

    // Amount 5: one, one, half, then vend.
    begin_run(5);
    ev(K_ONE, 1); ev(K_ONE, 5); ev(K_HALF, 9); ev(K_DONE, 13);
    set_busy(1, 12);
    end_start();
    cola(12);
    drain(16);

    // Amount 1: single half coin, no vend -> timeout.
    begin_run(1);
    ev(K_HALF, 1); ev(K_TMO, 18);
    set_busy(1, 17);
    end_start();
    drain(22);

    // Amount 6 with a second start while busy (ignored).
    begin_run(6);
    ev(K_ONE, 1); ev(K_ONE, 5); ev(K_ONE, 9); ev(K_DONE, 12);
    set_busy(1, 11);
    end_start();
    at(3); bus.iStart = 1'b1; bus.iAmount = AMT_W'(2);
    at(4); bus.iStart = 1'b0;
    cola(11);
    drain(15);

    // Amount 8 with early vend, then back-to-back start in the oDone cycle.
    begin_run(8);
    ev(K_ONE, 1); ev(K_ONE, 5); ev(K_DONE, 7);
    set_busy(1, 6);
    end_start();
    cola(6);
    at(7);
    begin_run(2);
    ev(K_ONE, 1); ev(K_DONE, 3);
    set_busy(1, 2);
    end_start();
    cola(2);
    drain(6);

    // Zero amount and iCola in IDLE are both ignored.
    begin_run(0);
    end_start();
    cola(3);
    drain(8);

    // Reset in a gap cycle of an amount-8 run.
    begin_run(8);
    ev(K_ONE, 1); ev(K_ONE, 5);
    set_busy(1, 6);
    end_start();
    at(6);
    #2 sysRstN = 1'b0;
    #1 chk_all_zero("mid reset gap");
    at(8);
    sysRstN = 1'b1;
    drain(30);

    // Reset while a coin pulse is high drops it.
    begin_run(8);
    ev(K_ONE, 1); ev(K_ONE, 5);
    set_busy(1, 5);
    end_start();
    at(5);
    #2 sysRstN = 1'b0;
    #1 chk_all_zero("mid reset coin");
    at(7);
    sysRstN = 1'b1;
    drain(20);
    n_done = 0;

    // Normal run after reset.
    begin_run(3);
    ev(K_ONE, 1); ev(K_HALF, 5); ev(K_DONE, 8);
    set_busy(1, 7);
    end_start();
    cola(7);
    drain(11);
    n_done++;

    // iCola on the timeout edge: oDone wins.
    begin_run(1);
    ev(K_HALF, 1); ev(K_DONE, 18);
    set_busy(1, 17);
    end_start();
    cola(17);
    drain(22);
    n_done++;

    // Maximum amount 15: seven ones, one half, timeout.
    begin_run(15);
    for (int k = 0; k < 7; k++) ev(K_ONE, 1 + GAP * k);
    ev(K_HALF, 29); ev(K_TMO, 46);
    set_busy(1, 45);
    end_start();
    drain(50);

`ifdef PAY_STATS_EN
    chk("oVendCnt after mixed runs", int'(vend_cnt), n_done);
    for (int r = 0; r < 300; r++) begin
      begin_run(1);
      ev(K_HALF, 1); ev(K_DONE, 2);
      set_busy(1, 1);
      end_start();
      cola(1);
      n_done++;
    end
    drain(4);
    chk("oVendCnt saturated", int'(vend_cnt), (n_done > 255) ? 255 : n_done);
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
